alu_arbiter: RTL
================

Name: alu_arbiter

Overview:
Shares the single multi-cycle ALU between two requesters. Requester 0 is the control unit execute path and requester 1 is the debug/self-test port. The block round-robin arbitrates and launches the ALU with a one-cycle start pulse. It then waits for the ALU done handshake, routes the result back to the granted requester, and aborts with an error if the ALU never answers. It sits between the requesters and the ALU's incoming/done interface.

Parameters:
WIDTH, 16, operand/result width
OPW, 4, ALU operator width
TIMEOUT, 64, max WAIT cycles before abort (>=2)
TW, 7, timer width; must hold TIMEOUT-1

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
req0  in  1  requester 0 request (level)
a0, b0  in  WIDTH  requester 0 operands
op0  in  OPW  requester 0 operator
req1  in  1  requester 1 request (level)
a1, b1  in  WIDTH  requester 1 operands
op1  in  OPW  requester 1 operator
ack0, ack1  out  1  operands captured (1-cycle pulse)
rsp_valid0, rsp_valid1  out  1  result valid (1-cycle pulse)
rsp_y  out  WIDTH  result, shared by both requesters
rsp_carry, rsp_signov  out  1  result flags
rsp_err  out  1  transaction timed out
busy  out  1  state != IDLE
alu_start  out  1  ALU launch pulse (drives ALU incoming)
alu_a, alu_b  out  WIDTH  ALU operands
alu_op  out  OPW  ALU operator
alu_done  in  1  ALU result ready
alu_y  in  WIDTH  ALU result
alu_carry, alu_signov  in  1  ALU flags
op_count  out  16  completed (non-error) transactions, wraps

Behaviour:
- Clock and reset:
  - One clock. Reset is synchronous and active-low: when rst_n=0 at a clk edge, the FSM goes to IDLE.
  - Reset clears all outputs to 0, clears op_count and the timer, and sets last_gnt=1 (req0 wins the first tie).
  - Reset mid-transaction abandons it: no ack, no rsp_valid, and alu_start is not re-issued.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - At the edge, if req0|req1 is high, pick the winner gnt:
    - Only one request high: that requester.
    - Both high: the requester != last_gnt.
  - Register a/b/op of the winner into alu_a/alu_b/alu_op, then go to ISSUE.
  - No request: stay in IDLE.
- ISSUE (exactly 1 cycle):
  - alu_start=1.
  - ack[gnt]=1.
  - Timer cleared; go to WAIT.
  - alu_done is ignored in this state.
- WAIT:
  - Timer increments each cycle.
  - alu_done=1 at an edge: capture alu_y/alu_carry/alu_signov into rsp_y/rsp_carry/rsp_signov, set rsp_err=0, go to RESP.
  - Otherwise, when the timer reaches TIMEOUT-1: set rsp_y=0, carry=0, signov=0, rsp_err=1, go to RESP.
  - alu_done wins if both conditions hold at the same edge.
- RESP (exactly 1 cycle):
  - rsp_valid[gnt]=1.
  - last_gnt<=gnt.
  - op_count+=1 if !rsp_err; wraps 0xFFFF->0.
  - Go to IDLE.
- Result hold: rsp_y/rsp_carry/rsp_signov/rsp_err hold their values until the next capture.
- Output stability: alu_a/alu_b/alu_op hold from capture until the next capture. Requester inputs may change after ack.
- Request rules:
  - req still high in IDLE after RESP counts as a new request.
  - A requester drops req after ack unless it wants another transaction.
- Fairness: with both requesters continuously requesting, grants strictly alternate.
- Latency:
  - Request sampled at edge E0 -> ack/alu_start in cycle E0..E1.
  - If the ALU raises alu_done for the edge one cycle after the start pulse (E2 sample), rsp_valid is high in cycle E2..E3.
  - Minimum request-to-response latency: 3 cycles.
- Throughput: IDLE costs at least 1 cycle between transactions, so at most one transaction per 4 cycles.
- busy=1 in ISSUE, WAIT and RESP.
- Only one of ack0/ack1 and one of rsp_valid0/rsp_valid1 is ever high at a time.

Test Plan:
- Single op, done one cycle after start: req0, a0=0x0003, b0=0x0004, op0=ADD; ALU model returns 0x0007 with done one cycle after start -> ack0 one cycle after the req edge; alu_start coincident with ack0; rsp_valid0 pulses with rsp_y=0x0007, rsp_err=0; op_count=1; ack1/rsp_valid1 stay 0.
- Tie after reset: req0=req1=1 held -> grants go 0,1,0,1; each rsp_valid matches the granted requester; operands seen on alu_a match that requester.
- Timeout abort: ALU model never asserts done -> rsp_valid[gnt] exactly TIMEOUT cycles after the first WAIT cycle; rsp_err=1, rsp_y=0; op_count unchanged; the next request proceeds normally.
- Done/timeout coincidence: alu_done asserted exactly at the timer=TIMEOUT-1 edge -> rsp_err=0 and the ALU result is returned.
- Reset mid-transaction: rst_n=0 for one cycle while in WAIT -> busy=0 and all pulse outputs 0 the next cycle; no rsp_valid for the aborted op; a late alu_done in IDLE is ignored; a subsequent tie grants req0.
- Spurious and wrapping inputs: alu_done held high during ISSUE is ignored and the WAIT capture still occurs; preload op_count to 0xFFFF via 65535 ops (or force) -> the next success gives op_count=0x0000.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin share of one multi-cycle ALU between the
// execute path (req0) and the debug/self-test port (req1).
module alu_arbiter #(
   parameter int WIDTH   = 16,
   parameter int OPW     = 4,
   parameter int TIMEOUT = 64,
   parameter int TW      = 7
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0,
   input  logic [WIDTH-1:0] a0,
   input  logic [WIDTH-1:0] b0,
   input  logic [OPW-1:0]   op0,
   input  logic             req1,
   input  logic [WIDTH-1:0] a1,
   input  logic [WIDTH-1:0] b1,
   input  logic [OPW-1:0]   op1,
   output logic             ack0,
   output logic             ack1,
   output logic             rsp_valid0,
   output logic             rsp_valid1,
   output logic [WIDTH-1:0] rsp_y,
   output logic             rsp_carry,
   output logic             rsp_signov,
   output logic             rsp_err,
   output logic             busy,
   output logic             alu_start,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [OPW-1:0]   alu_op,
   input  logic             alu_done,
   input  logic [WIDTH-1:0] alu_y,
   input  logic             alu_carry,
   input  logic             alu_signov,
   output logic [15:0]      op_count
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RESP
   } state_t;

   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

   state_t        r_state;
   logic          r_gnt;
   logic          r_last_gnt;
   logic [TW-1:0] r_timer;
   logic          w_gnt;

   // Winner: a lone requester, or on a tie the one not served last
   always_comb begin
      w_gnt = 1'b0;
      if (req0 && req1) begin
         w_gnt = ~r_last_gnt;
      end else if (req1) begin
         w_gnt = 1'b1;
      end
   end

   assign busy = (r_state != S_IDLE);

   // Arbitration FSM with all handshake/result outputs registered
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_gnt      <= 1'b0;
         r_last_gnt <= 1'b1;
         r_timer    <= '0;
         ack0       <= 1'b0;
         ack1       <= 1'b0;
         rsp_valid0 <= 1'b0;
         rsp_valid1 <= 1'b0;
         rsp_y      <= '0;
         rsp_carry  <= 1'b0;
         rsp_signov <= 1'b0;
         rsp_err    <= 1'b0;
         alu_start  <= 1'b0;
         alu_a      <= '0;
         alu_b      <= '0;
         alu_op     <= '0;
         op_count   <= '0;
      end else begin
         ack0       <= 1'b0;
         ack1       <= 1'b0;
         rsp_valid0 <= 1'b0;
         rsp_valid1 <= 1'b0;
         alu_start  <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (req0 || req1) begin
                  r_gnt     <= w_gnt;
                  alu_a     <= w_gnt ? a1 : a0;
                  alu_b     <= w_gnt ? b1 : b0;
                  alu_op    <= w_gnt ? op1 : op0;
                  ack0      <= ~w_gnt;
                  ack1      <= w_gnt;
                  alu_start <= 1'b1;
                  r_state   <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               r_timer <= '0;
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               if (alu_done) begin
                  rsp_y      <= alu_y;
                  rsp_carry  <= alu_carry;
                  rsp_signov <= alu_signov;
                  rsp_err    <= 1'b0;
                  rsp_valid0 <= ~r_gnt;
                  rsp_valid1 <= r_gnt;
                  r_state    <= S_RESP;
               end else if (r_timer == TMAX) begin
                  rsp_y      <= '0;
                  rsp_carry  <= 1'b0;
                  rsp_signov <= 1'b0;
                  rsp_err    <= 1'b1;
                  rsp_valid0 <= ~r_gnt;
                  rsp_valid1 <= r_gnt;
                  r_state    <= S_RESP;
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end
            S_RESP: begin
               r_last_gnt <= r_gnt;
               if (!rsp_err) begin
                  op_count <= op_count + 16'd1;
               end
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
